accelerator_forward_weighting: RTL and testbench

DNC read-side consumer of the temporal link matrix stream. It computes the forward weighting f(t)[g] = sum_j L(t)[g;j]·w(t-1;j) for one read head.
- First loads the previous read weighting vector w into a local buffer.
- Then accepts L row-major, one element per strobe, and emits one f element per completed row.
- Sits downstream of the link-matrix block and feeds the read-mode mixer.

---
 rtl/accelerator_dnc_pkg.sv | 28 ++
 rtl/accelerator_forward_weighting_if.sv | 33 +++
 rtl/accelerator_fixed_mac.sv | 21 ++
 rtl/accelerator_forward_weighting.sv | 126 ++++++++++++
 tb/tb_accelerator_forward_weighting.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/accelerator_dnc_pkg.sv
// Shared definitions for the DNC read-side accelerators: FSM encoding,
// fixed-point constants and the multiply-shift helper.
package accelerator_dnc_pkg;

    typedef enum logic [1:0] {
        STARTER = 2'd0,
        W_LOAD  = 2'd1,
        L_ROW   = 2'd2
    } fsm_state_t;

    localparam int MAX_DATA_SIZE         = 64;
    localparam int DEFAULT_FRACTION_SIZE = 32;

    localparam logic [MAX_DATA_SIZE-1:0] ZERO_DATA = '0;
    localparam logic [MAX_DATA_SIZE-1:0] ONE_DATA  = MAX_DATA_SIZE'(1) << DEFAULT_FRACTION_SIZE;

    // Full-precision signed product, then floor toward -inf by the fraction width.
    function automatic logic signed [2*MAX_DATA_SIZE-1:0] fixed_mul_shift(
        input logic signed [MAX_DATA_SIZE-1:0] a,
        input logic signed [MAX_DATA_SIZE-1:0] b,
        input int unsigned                     frac
    );
        logic signed [2*MAX_DATA_SIZE-1:0] prod;
        prod = (2*MAX_DATA_SIZE)'(a) * (2*MAX_DATA_SIZE)'(b);
        return prod >>> frac;
    endfunction

endpackage

// File: rtl/accelerator_forward_weighting_if.sv
// Stream interface of the forward-weighting block: weighting load, link-matrix
// stream in, forward weighting out, plus the FSM state for observation.
interface accelerator_forward_weighting_if
    import accelerator_dnc_pkg::*;
#(
    parameter int DATA_SIZE = 64
);
    // All *_ENABLE/START inputs are single-cycle strobes sampled on the rising
    // edge; there is no ready/backpressure, the block takes one item per cycle.
    // READY and F_OUT_ENABLE are one-cycle pulses; F_OUT holds between pulses.
    logic                 START;
    logic                 READY;
    logic [DATA_SIZE-1:0] SIZE_N_IN;
    logic                 W_IN_ENABLE;
    logic [DATA_SIZE-1:0] W_IN;
    logic                 L_IN_G_ENABLE;
    logic                 L_IN_J_ENABLE;
    logic [DATA_SIZE-1:0] L_IN;
    logic                 F_OUT_ENABLE;
    logic [DATA_SIZE-1:0] F_OUT;
    fsm_state_t           dbg_state;

    modport master (
        output START, SIZE_N_IN, W_IN_ENABLE, W_IN, L_IN_G_ENABLE, L_IN_J_ENABLE, L_IN,
        input  READY, F_OUT_ENABLE, F_OUT, dbg_state
    );

    modport slave (
        input  START, SIZE_N_IN, W_IN_ENABLE, W_IN, L_IN_G_ENABLE, L_IN_J_ENABLE, L_IN,
        output READY, F_OUT_ENABLE, F_OUT, dbg_state
    );

endinterface

// File: rtl/accelerator_fixed_mac.sv
// Combinational fixed-point multiply-accumulate: ACC_OUT = ACC_IN + floor(A*B / 2^FRACTION_SIZE),
// wrapping at DATA_SIZE bits.
module accelerator_fixed_mac
    import accelerator_dnc_pkg::*;
#(
    parameter int DATA_SIZE     = 64,
    parameter int FRACTION_SIZE = 32
) (
    input  logic [DATA_SIZE-1:0] A,
    input  logic [DATA_SIZE-1:0] B,
    input  logic [DATA_SIZE-1:0] ACC_IN,
    output logic [DATA_SIZE-1:0] ACC_OUT
);

    always_comb begin
        ACC_OUT = ACC_IN + DATA_SIZE'(fixed_mul_shift(MAX_DATA_SIZE'($signed(A)),
                                                      MAX_DATA_SIZE'($signed(B)),
                                                      FRACTION_SIZE));
    end

endmodule

// File: rtl/accelerator_forward_weighting.sv
// Forward weighting f[g] = sum_j L[g;j]*w[j]: buffers w, then reduces each
// streamed row of the link matrix to one output element.
module accelerator_forward_weighting
    import accelerator_dnc_pkg::*;
#(
    parameter int DATA_SIZE     = 64,
    parameter int FRACTION_SIZE = 32,
    parameter int N_MAX         = 16
) (
    input logic                              CLK,
    input logic                              RST,
    accelerator_forward_weighting_if.slave   bus
);

    localparam int IDX_W = $clog2(N_MAX + 1);
    localparam int BUF_W = (N_MAX > 1) ? $clog2(N_MAX) : 1;

    fsm_state_t           state;
    logic [IDX_W-1:0]     n;
    logic [IDX_W-1:0]     j;
    logic [IDX_W-1:0]     g;
    logic [DATA_SIZE-1:0] acc;
    logic [DATA_SIZE-1:0] w_buf [N_MAX];

    logic                 resync;
    logic [IDX_W-1:0]     j_eff;
    logic [IDX_W-1:0]     n_minus1;
    logic [IDX_W-1:0]     n_clamped;
    logic [DATA_SIZE-1:0] acc_base;
    logic [DATA_SIZE-1:0] acc_next;
    logic [DATA_SIZE-1:0] w_sel;
    logic                 last_elem;
    logic                 last_row;

    // A row-start marker in mid-row restarts the same row from element 0.
    always_comb begin
        resync    = bus.L_IN_G_ENABLE && (j != '0);
        j_eff     = resync ? '0 : j;
        acc_base  = bus.L_IN_G_ENABLE ? DATA_SIZE'(ZERO_DATA) : acc;
        w_sel     = w_buf[j_eff[BUF_W-1:0]];
        n_minus1  = n - IDX_W'(1);
        last_elem = (j_eff == n_minus1);
        last_row  = (g == n_minus1);
        n_clamped = (bus.SIZE_N_IN > DATA_SIZE'(N_MAX)) ? IDX_W'(N_MAX)
                                                        : bus.SIZE_N_IN[IDX_W-1:0];
    end

    accelerator_fixed_mac #(
        .DATA_SIZE     (DATA_SIZE),
        .FRACTION_SIZE (FRACTION_SIZE)
    ) u_mac (
        .A       (bus.L_IN),
        .B       (w_sel),
        .ACC_IN  (acc_base),
        .ACC_OUT (acc_next)
    );

    assign bus.dbg_state = state;

    always_ff @(posedge CLK) begin
        if (state == W_LOAD && bus.W_IN_ENABLE) begin
            w_buf[j[BUF_W-1:0]] <= bus.W_IN;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state            <= STARTER;
            n                <= '0;
            j                <= '0;
            g                <= '0;
            acc              <= '0;
            bus.READY        <= 1'b0;
            bus.F_OUT_ENABLE <= 1'b0;
            bus.F_OUT        <= '0;
        end else begin
            bus.READY        <= 1'b0;
            bus.F_OUT_ENABLE <= 1'b0;
            case (state)
                STARTER: begin
                    if (bus.START) begin
                        n   <= n_clamped;
                        j   <= '0;
                        g   <= '0;
                        acc <= '0;
                        if (n_clamped == '0) begin
                            bus.READY <= 1'b1;
                        end else begin
                            state <= W_LOAD;
                        end
                    end
                end
                W_LOAD: begin
                    if (bus.W_IN_ENABLE) begin
                        if (j == n_minus1) begin
                            j     <= '0;
                            state <= L_ROW;
                        end else begin
                            j <= j + IDX_W'(1);
                        end
                    end
                end
                L_ROW: begin
                    if (bus.L_IN_J_ENABLE) begin
                        if (last_elem) begin
                            bus.F_OUT        <= acc_next;
                            bus.F_OUT_ENABLE <= 1'b1;
                            acc              <= '0;
                            j                <= '0;
                            g                <= g + IDX_W'(1);
                            if (last_row) begin
                                bus.READY <= 1'b1;
                                state     <= STARTER;
                            end
                        end else begin
                            acc <= acc_next;
                            j   <= j_eff + IDX_W'(1);
                        end
                    end
                end
                default: state <= STARTER;
            endcase
        end
    end

endmodule

// File: tb/tb_accelerator_forward_weighting.sv
// Self-checking bench for accelerator_forward_weighting at DATA_SIZE=16,
// FRACTION_SIZE=8, N_MAX=4.
module tb_accelerator_forward_weighting;
    import accelerator_dnc_pkg::*;

    localparam int DW = 16;
    localparam int FW = 8;
    localparam int NM = 4;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    accelerator_forward_weighting_if #(.DATA_SIZE(DW)) bus ();

    accelerator_forward_weighting #(
        .DATA_SIZE     (DW),
        .FRACTION_SIZE (FW),
        .N_MAX         (NM)
    ) dut (
        .CLK (clk),
        .RST (rst_n),
        .bus (bus)
    );

    // ---------------- scoreboard state ----------------
    int checks      = 0;
    int errors      = 0;
    int pulse_cnt   = 0;
    int ready_cnt   = 0;
    int exp_pulses  = 0;
    int exp_ready   = 0;
    logic [DW-1:0] exp_q [$];

    logic [DW-1:0] m_w [NM];
    logic [DW-1:0] m_l [NM][NM];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: plain fixed-point dot product of row g with w.
    function automatic logic [DW-1:0] model_row(input int n, input int g);
        longint acc;
        longint p;
        acc = 0;
        for (int k = 0; k < n; k++) begin
            p   = longint'($signed(m_l[g][k])) * longint'($signed(m_w[k]));
            acc = acc + (p >>> FW);
        end
        return acc[DW-1:0];
    endfunction

    task automatic set_w(input logic [DW-1:0] a, b, c, d);
        m_w[0] = a; m_w[1] = b; m_w[2] = c; m_w[3] = d;
    endtask

    task automatic set_row(input int g, input logic [DW-1:0] a, b, c, d);
        m_l[g][0] = a; m_l[g][1] = b; m_l[g][2] = c; m_l[g][3] = d;
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (rst_n && bus.F_OUT_ENABLE) begin
            pulse_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL f_out_unexpected: got pulse with 0x%0h expected no pulse at %0t",
                         bus.F_OUT, $time);
            end else begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                if (bus.F_OUT !== e) begin
                    errors++;
                    $display("FAIL f_out: got 0x%0h expected 0x%0h at %0t", bus.F_OUT, e, $time);
                end
            end
        end
        if (rst_n && bus.READY) ready_cnt++;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.START         = 1'b0;
        bus.SIZE_N_IN     = '0;
        bus.W_IN_ENABLE   = 1'b0;
        bus.W_IN          = '0;
        bus.L_IN_G_ENABLE = 1'b0;
        bus.L_IN_J_ENABLE = 1'b0;
        bus.L_IN          = '0;
    endtask

    task automatic start(input int n);
        bus.SIZE_N_IN = DW'(n);
        bus.START     = 1'b1;
        tick();
        bus.START     = 1'b0;
    endtask

    task automatic load_w(input int n);
        for (int k = 0; k < n; k++) begin
            bus.W_IN_ENABLE = 1'b1;
            bus.W_IN        = m_w[k];
            tick();
        end
        bus.W_IN_ENABLE = 1'b0;
    endtask

    // Streams the model matrix back-to-back and checks pulse/READY timing.
    task automatic send_matrix(input int n);
        for (int g = 0; g < n; g++) exp_q.push_back(model_row(n, g));
        exp_pulses += n;
        exp_ready  += 1;
        for (int g = 0; g < n; g++) begin
            for (int k = 0; k < n; k++) begin
                bus.L_IN          = m_l[g][k];
                bus.L_IN_J_ENABLE = 1'b1;
                bus.L_IN_G_ENABLE = (k == 0);
                tick();
                if (k == n - 1) begin
                    check($sformatf("pulse_timing_g%0d", g), 32'(bus.F_OUT_ENABLE), 32'd1);
                    check($sformatf("ready_timing_g%0d", g), 32'(bus.READY), 32'(g == n - 1));
                end
            end
        end
        bus.L_IN_J_ENABLE = 1'b0;
        bus.L_IN_G_ENABLE = 1'b0;
        tick();
        check("pulse_single_cycle", 32'(bus.F_OUT_ENABLE), 32'd0);
    endtask

    task automatic setup_s1();
        set_w(16'h0100, 16'h0080, 16'h0000, 16'h0000);
        set_row(0, 16'h0100, 16'h0100, 16'h0000, 16'h0000);
        set_row(1, 16'h0000, 16'h0200, 16'h0000, 16'h0000);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // ---------------- directed scenarios ----------------
    initial begin
        idle_inputs();
        #2;
        check("reset_ready", 32'(bus.READY), 32'd0);
        check("reset_fen", 32'(bus.F_OUT_ENABLE), 32'd0);
        check("reset_fout", 32'(bus.F_OUT), 32'd0);
        check("reset_state", 32'(bus.dbg_state), 32'(STARTER));
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Basic N=2
        setup_s1();
        check("model_s1_f0", 32'(model_row(2, 0)), 32'h0180);
        check("model_s1_f1", 32'(model_row(2, 1)), 32'h0100);
        start(2);
        load_w(2);
        send_matrix(2);
        repeat (3) tick();
        check("f_out_hold", 32'(bus.F_OUT), 32'h0100);

        // Negative weight, floor rounding
        set_w(16'hFF80, 16'h0000, 16'h0000, 16'h0000);
        set_row(0, 16'h0001, 16'h0000, 16'h0000, 16'h0000);
        check("model_floor", 32'(model_row(1, 0)), 32'hFFFF);
        start(1);
        load_w(1);
        send_matrix(1);

        // Resync: the 0x0300 element is discarded
        set_w(16'h0100, 16'h0100, 16'h0000, 16'h0000);
        set_row(0, 16'h0100, 16'h0100, 16'h0000, 16'h0000);
        set_row(1, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        check("model_resync", 32'(model_row(2, 0)), 32'h0200);
        start(2);
        load_w(2);
        exp_q.push_back(16'h0200);
        exp_q.push_back(16'h0000);
        exp_pulses += 2;
        exp_ready  += 1;
        bus.L_IN_J_ENABLE = 1'b1;
        bus.L_IN_G_ENABLE = 1'b1; bus.L_IN = 16'h0300; tick();
        check("resync_no_pulse0", 32'(bus.F_OUT_ENABLE), 32'd0);
        bus.L_IN_G_ENABLE = 1'b1; bus.L_IN = 16'h0100; tick();
        check("resync_no_pulse1", 32'(bus.F_OUT_ENABLE), 32'd0);
        bus.L_IN_G_ENABLE = 1'b0; bus.L_IN = 16'h0100; tick();
        check("resync_pulse", 32'(bus.F_OUT_ENABLE), 32'd1);
        bus.L_IN_G_ENABLE = 1'b1; bus.L_IN = 16'h0000; tick();
        bus.L_IN_G_ENABLE = 1'b0; bus.L_IN = 16'h0000; tick();
        check("resync_ready", 32'(bus.READY), 32'd1);
        bus.L_IN_J_ENABLE = 1'b0;
        tick();

        // N=0: READY one cycle after START, no output
        exp_ready += 1;
        start(0);
        check("n0_ready", 32'(bus.READY), 32'd1);
        check("n0_no_fen", 32'(bus.F_OUT_ENABLE), 32'd0);
        check("n0_state", 32'(bus.dbg_state), 32'(STARTER));
        tick();
        check("n0_ready_pulse", 32'(bus.READY), 32'd0);

        // N=9 clamped to 4, including a wrapping row
        set_w(16'h0100, 16'h0200, 16'hFF00, 16'h0080);
        set_row(0, 16'h0100, 16'h0100, 16'h0100, 16'h0100);
        set_row(1, 16'h0010, 16'h0020, 16'h0030, 16'h0040);
        set_row(2, 16'hFFF0, 16'h0100, 16'h0000, 16'h0200);
        set_row(3, 16'h7FFF, 16'h7FFF, 16'h0001, 16'hFFFF);
        check("model_clamp_f0", 32'(model_row(4, 0)), 32'h0280);
        start(9);
        check("clamp_state_wload", 32'(bus.dbg_state), 32'(W_LOAD));
        load_w(4);
        check("clamp_state_lrow", 32'(bus.dbg_state), 32'(L_ROW));
        send_matrix(4);
        bus.L_IN_J_ENABLE = 1'b1;
        for (int k = 0; k < 5; k++) begin
            bus.L_IN = DW'(k + 1);
            tick();
        end
        bus.L_IN_J_ENABLE = 1'b0;
        check("extra_strobes_state", 32'(bus.dbg_state), 32'(STARTER));

        // Reset in the middle of the second row
        setup_s1();
        start(2);
        load_w(2);
        exp_q.push_back(16'h0180);
        exp_pulses += 1;
        bus.L_IN_J_ENABLE = 1'b1;
        bus.L_IN_G_ENABLE = 1'b1; bus.L_IN = m_l[0][0]; tick();
        bus.L_IN_G_ENABLE = 1'b0; bus.L_IN = m_l[0][1]; tick();
        bus.L_IN_G_ENABLE = 1'b1; bus.L_IN = m_l[1][0]; tick();
        rst_n = 1'b0;
        #1;
        check("midrst_ready", 32'(bus.READY), 32'd0);
        check("midrst_fen", 32'(bus.F_OUT_ENABLE), 32'd0);
        check("midrst_fout", 32'(bus.F_OUT), 32'd0);
        check("midrst_state", 32'(bus.dbg_state), 32'(STARTER));
        idle_inputs();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        start(2);
        load_w(2);
        send_matrix(2);

        // START and L strobes ignored in W_LOAD, then back-to-back rows
        set_w(16'h0200, 16'hFF00, 16'h0000, 16'h0000);
        set_row(0, 16'h0180, 16'h0100, 16'h0000, 16'h0000);
        set_row(1, 16'hFF00, 16'h0040, 16'h0000, 16'h0000);
        check("model_s6_f0", 32'(model_row(2, 0)), 32'h0200);
        check("model_s6_f1", 32'(model_row(2, 1)), 32'hFDC0);
        start(2);
        bus.START = 1'b1; bus.SIZE_N_IN = 16'd3;
        bus.L_IN_J_ENABLE = 1'b1; bus.L_IN_G_ENABLE = 1'b1; bus.L_IN = 16'h7777;
        tick();
        check("wload_ignore_start", 32'(bus.dbg_state), 32'(W_LOAD));
        bus.START = 1'b0; bus.L_IN_G_ENABLE = 1'b0;
        bus.W_IN_ENABLE = 1'b1; bus.W_IN = m_w[0];
        tick();
        bus.START = 1'b1; bus.W_IN_ENABLE = 1'b0; bus.L_IN_J_ENABLE = 1'b0;
        tick();
        bus.START = 1'b0; bus.W_IN_ENABLE = 1'b1; bus.W_IN = m_w[1];
        tick();
        bus.W_IN_ENABLE = 1'b0;
        check("wload_done_state", 32'(bus.dbg_state), 32'(L_ROW));
        send_matrix(2);

        // ---------------- final report ----------------
        repeat (3) tick();
        check("pulse_count", 32'(pulse_cnt), 32'(exp_pulses));
        check("ready_count", 32'(ready_cnt), 32'(exp_ready));
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
